// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation codes, FSM state type and iteration count
// for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

   localparam int ITER = 32;

   localparam logic [2:0] MULDIV_MUL    = 3'b000;
   localparam logic [2:0] MULDIV_MULH   = 3'b001;
   localparam logic [2:0] MULDIV_MULHSU = 3'b010;
   localparam logic [2:0] MULDIV_MULHU  = 3'b011;
   localparam logic [2:0] MULDIV_DIV    = 3'b100;
   localparam logic [2:0] MULDIV_DIVU   = 3'b101;
   localparam logic [2:0] MULDIV_REM    = 3'b110;
   localparam logic [2:0] MULDIV_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } muldivState_e;

   // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
   function automatic logic isSignedA(input logic [2:0] funct3);
      return (funct3 == MULDIV_MULH) || (funct3 == MULDIV_MULHSU) ||
             (funct3 == MULDIV_DIV)  || (funct3 == MULDIV_REM);
   endfunction

   // rs2 is treated as two's complement for MULH, DIV and REM
   function automatic logic isSignedB(input logic [2:0] funct3);
      return (funct3 == MULDIV_MULH) || (funct3 == MULDIV_DIV) ||
             (funct3 == MULDIV_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// ex_muldiv_sign_fix: turns the unsigned magnitudes left by the iteration
// loop into the final architectural result: sign restore, half/quotient/
// remainder select, and the divide-by-zero / signed-overflow overrides.
module ex_muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] accHi_i,
   input  logic [XLEN-1:0] accLo_i,
   input  logic            negResult_i,
   input  logic            negRem_i,
   input  logic [XLEN-1:0] opA_i,
   input  logic            divZero_i,
   input  logic            overflow_i,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [2*XLEN-1:0] productFix;
   logic [XLEN-1:0]   quotFix;
   logic [XLEN-1:0]   remFix;

   // Restore signs: product and quotient follow the operand sign mismatch, remainder follows the dividend
   always_comb begin
      productFix = negResult_i ? ('0 - {accHi_i, accLo_i}) : {accHi_i, accLo_i};
      quotFix    = negResult_i ? ('0 - accLo_i) : accLo_i;
      remFix     = negRem_i ? ('0 - accHi_i) : accHi_i;
   end

   // Pick the requested half or quotient/remainder, letting divide corner cases win over the datapath
   always_comb begin
      result_o = '0;
      case (funct3_i)
         MULDIV_MUL:                      result_o = productFix[XLEN-1:0];
         MULDIV_MULH, MULDIV_MULHSU,
         MULDIV_MULHU:                    result_o = productFix[2*XLEN-1:XLEN];
         MULDIV_DIV, MULDIV_DIVU: begin
            if (divZero_i)                result_o = '1;
            else if (overflow_i)          result_o = MIN_NEG;
            else                          result_o = quotFix;
         end
         default: begin
            if (divZero_i)                result_o = opA_i;
            else if (overflow_i)          result_o = '0;
            else                          result_o = remFix;
         end
      endcase
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit sitting in EX. One
// shift-add or restoring-subtract step per cycle over 32 cycles; busy_o
// holds the front of the pipeline while the loop runs.
// Optional build macro MULDIV_FASTPATH_EN: divides by zero and signed
// overflow divides jump straight from IDLE to FINISH.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int              CW         = $clog2(ITER);
   localparam logic [CW-1:0]   LAST_COUNT = CW'(ITER - 1);
   localparam logic [XLEN-1:0] MIN_NEG    = {1'b1, {(XLEN-1){1'b0}}};

   muldivState_e    state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] accHi_q, accHi_d;
   logic [XLEN-1:0] accLo_q, accLo_d;
   logic [XLEN-1:0] magB_q;
   logic [XLEN-1:0] opA_q;
   logic [2:0]      funct3_q;
   logic            negRes_q;
   logic            negRem_q;
   logic            divZero_q;
   logic            overflow_q;
   logic [XLEN-1:0] result_q;

   logic            negAIn, negBIn;
   logic [XLEN-1:0] magAIn, magBIn;
   logic            divZeroIn, overflowIn;
   logic            acceptStart;
   logic            fastPath;
   logic [XLEN:0]   mulSum;
   logic [XLEN:0]   divShift;
   logic [XLEN-1:0] divDiff;
   logic [XLEN-1:0] fixResult;

   // Decode the instruction sitting in ID/EX: operand signs, magnitudes and divide corner cases
   always_comb begin
      negAIn      = isSignedA(funct3_i) & op_a_i[XLEN-1];
      negBIn      = isSignedB(funct3_i) & op_b_i[XLEN-1];
      magAIn      = negAIn ? ('0 - op_a_i) : op_a_i;
      magBIn      = negBIn ? ('0 - op_b_i) : op_b_i;
      divZeroIn   = funct3_i[2] & (op_b_i == '0);
      overflowIn  = funct3_i[2] & ~funct3_i[0] & (op_a_i == MIN_NEG) & (op_b_i == '1);
      acceptStart = (state_q == IDLE) & start_i & ~flush_i;
   end

`ifdef MULDIV_FASTPATH_EN
   assign fastPath = divZeroIn | overflowIn;
`else
   assign fastPath = 1'b0;
`endif

   // State register; reset aborts any operation in flight
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a flush always returns to IDLE, otherwise walk IDLE -> CALC -> FINISH
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = fastPath ? FINISH : CALC;
         CALC:    if (count_q == LAST_COUNT) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) begin
         state_d = IDLE;
      end
   end

   // Stall the pipeline from the arrival cycle through the last iteration; signal completion in FINISH
   always_comb begin
      busy_o = (state_q == CALC) | acceptStart;
      done_o = (state_q == FINISH) & ~flush_i;
   end

   // One iteration per cycle: shift-add for multiply, restoring subtract for divide
   always_comb begin
      accHi_d  = accHi_q;
      accLo_d  = accLo_q;
      count_d  = count_q;
      mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, magB_q} : '0);
      divShift = {accHi_q, accLo_q[XLEN-1]};
      divDiff  = divShift[XLEN-1:0] - magB_q;
      if (acceptStart) begin
         accHi_d = '0;
         accLo_d = magAIn;
         count_d = '0;
      end else if (state_q == CALC) begin
         count_d = count_q + CW'(1);
         if (funct3_q[2]) begin
            if (divShift >= {1'b0, magB_q}) begin
               accHi_d = divDiff;
               accLo_d = {accLo_q[XLEN-2:0], 1'b1};
            end else begin
               accHi_d = divShift[XLEN-1:0];
               accLo_d = {accLo_q[XLEN-2:0], 1'b0};
            end
         end else begin
            accHi_d = mulSum[XLEN:1];
            accLo_d = {mulSum[0], accLo_q[XLEN-1:1]};
         end
      end
      if (flush_i) begin
         count_d = '0;
      end
   end

   // Datapath registers, operand latch on acceptance, and result capture on completion
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         accHi_q    <= '0;
         accLo_q    <= '0;
         count_q    <= '0;
         magB_q     <= '0;
         opA_q      <= '0;
         funct3_q   <= '0;
         negRes_q   <= 1'b0;
         negRem_q   <= 1'b0;
         divZero_q  <= 1'b0;
         overflow_q <= 1'b0;
         result_q   <= '0;
      end else begin
         accHi_q <= accHi_d;
         accLo_q <= accLo_d;
         count_q <= count_d;
         if (acceptStart) begin
            magB_q     <= magBIn;
            opA_q      <= op_a_i;
            funct3_q   <= funct3_i;
            negRes_q   <= negAIn ^ negBIn;
            negRem_q   <= negAIn;
            divZero_q  <= divZeroIn;
            overflow_q <= overflowIn;
         end
         if (done_o) begin
            result_q <= fixResult;
         end
      end
   end

   ex_muldiv_sign_fix #(
      .XLEN (XLEN)
   ) u_signFix (
      .funct3_i    (funct3_q),
      .accHi_i     (accHi_q),
      .accLo_i     (accLo_q),
      .negResult_i (negRes_q),
      .negRem_i    (negRem_q),
      .opA_i       (opA_q),
      .divZero_i   (divZero_q),
      .overflow_i  (overflow_q),
      .result_o    (fixResult)
   );

   // The fresh result is visible in the done cycle so EX/MEM can capture it on the edge that ends FINISH
   assign result_o = done_o ? fixResult : result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an
// arithmetic reference model (64-bit products, native division).
module tb_ex_muldiv;
   import muldiv_pkg::*;

   localparam int TIMEOUT = 100;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] op_a_i;
   logic [31:0] op_b_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   ex_muldiv #(.XLEN(32)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .flush_i  (flush_i),
      .funct3_i (funct3_i),
      .op_a_i   (op_a_i),
      .op_b_i   (op_b_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   // Architectural RV32M result computed with wide integer arithmetic
   function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     full;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = {32'd0, a};
      ub   = {32'd0, b};
      full = '0;
      case (f)
         MULDIV_MUL:    full = ua * ub;
         MULDIV_MULH:   full = sa * sb;
         MULDIV_MULHSU: full = sa * longint'(ub);
         MULDIV_MULHU:  full = ua * ub;
         MULDIV_DIV: begin
            if (b == 32'd0) full = 64'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) full = 64'h80000000;
            else full = sa / sb;
         end
         MULDIV_DIVU: begin
            if (b == 32'd0) full = 64'hFFFFFFFF;
            else full = ua / ub;
         end
         MULDIV_REM: begin
            if (b == 32'd0) full = {32'd0, a};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) full = 64'd0;
            else full = sa % sb;
         end
         default: begin
            if (b == 32'd0) full = {32'd0, a};
            else full = ua % ub;
         end
      endcase
      if (f[2] == 1'b0 && f != MULDIV_MUL) return full[63:32];
      return full[31:0];
   endfunction

   // Cycles from the start edge until done_o, counting the cycle after that edge as 1
   function automatic int expLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bit special;
      bit fastBuild;
      special = f[2] && ((b == 32'd0) ||
                ((f == MULDIV_DIV || f == MULDIV_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF));
`ifdef MULDIV_FASTPATH_EN
      fastBuild = 1'b1;
`else
      fastBuild = 1'b0;
`endif
      return (special && fastBuild) ? 1 : 33;
   endfunction

   // Issue one operation and observe its result, latency, stall length and done pulse width
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat, output int busyCnt,
                                output logic pulseOk, output logic [31:0] resAfter);
      funct3_i = f;
      op_a_i   = a;
      op_b_i   = b;
      start_i  = 1'b1;
      #1;
      busyCnt = (busy_o === 1'b1) ? 1 : 0;
      @(posedge clk_i); #1;
      start_i  = 1'b0;
      funct3_i = 3'($urandom_range(0, 7));
      op_a_i   = $urandom;
      op_b_i   = $urandom;
      lat = 1;
      while (done_o !== 1'b1 && lat < TIMEOUT) begin
         if (busy_o === 1'b1) busyCnt++;
         @(posedge clk_i); #1;
         lat++;
      end
      res = result_o;
      @(posedge clk_i); #1;
      pulseOk  = (done_o === 1'b0);
      resAfter = result_o;
   endtask

   task automatic test_reset();
      rst_i    = 1'b0;
      start_i  = 1'b0;
      flush_i  = 1'b0;
      funct3_i = '0;
      op_a_i   = '0;
      op_b_i   = '0;
      #12;
      nCompared++;
      if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
      nCompared++;
      if (done_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
      nCompared++;
      if (result_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_result: got %h expected 0", result_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_directed();
      vec_t        vecs [14];
      logic [31:0] res, resAfter;
      int          lat, busyCnt, expLat;
      logic        pulseOk;
      vecs = '{
         '{MULDIV_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
         '{MULDIV_MULH,   32'h80000000, 32'h80000000, 32'h40000000},
         '{MULDIV_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
         '{MULDIV_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
         '{MULDIV_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
         '{MULDIV_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
         '{MULDIV_DIVU,   32'd100,      32'd7,        32'd14},
         '{MULDIV_REMU,   32'd100,      32'd7,        32'd2},
         '{MULDIV_DIV,    32'd5,        32'd0,        32'hFFFFFFFF},
         '{MULDIV_REM,    32'd5,        32'd0,        32'd5},
         '{MULDIV_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000},
         '{MULDIV_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0},
         '{MULDIV_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF},
         '{MULDIV_REMU,   32'd5,        32'd0,        32'd5}
      };
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busyCnt, pulseOk, resAfter);
         expLat = expLatency(vecs[i].f, vecs[i].a, vecs[i].b);
         nCompared++;
         if (res !== vecs[i].exp) begin nMismatched++; $display("[TB] FAIL dir%0d_result: got %h expected %h", i, res, vecs[i].exp); end
         nCompared++;
         if (lat != expLat) begin nMismatched++; $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, lat, expLat); end
         nCompared++;
         if (busyCnt != expLat) begin nMismatched++; $display("[TB] FAIL dir%0d_busy: got %0d expected %0d", i, busyCnt, expLat); end
         nCompared++;
         if (pulseOk !== 1'b1) begin nMismatched++; $display("[TB] FAIL dir%0d_pulse: done_o still high, expected one-cycle pulse", i); end
         nCompared++;
         if (resAfter !== vecs[i].exp) begin nMismatched++; $display("[TB] FAIL dir%0d_hold: got %h expected %h", i, resAfter, vecs[i].exp); end
      end
   endtask

   // Randomized operations issued back to back, each starting in the IDLE cycle after FINISH
   task automatic test_random();
      logic [2:0]  f;
      logic [31:0] a, b, res, resAfter, exp;
      int          lat, busyCnt, expLat;
      logic        pulseOk;
      for (int i = 0; i < 24; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
            default: ;
         endcase
         applyStimulus(f, a, b, res, lat, busyCnt, pulseOk, resAfter);
         exp    = refModel(f, a, b);
         expLat = expLatency(f, a, b);
         nCompared++;
         if (res !== exp) begin nMismatched++; $display("[TB] FAIL rnd%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp); end
         nCompared++;
         if (lat != expLat) begin nMismatched++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", i, lat, expLat); end
         nCompared++;
         if (resAfter !== exp) begin nMismatched++; $display("[TB] FAIL rnd%0d_hold: got %h expected %h", i, resAfter, exp); end
      end
   endtask

   task automatic test_start_ignored();
      logic [31:0] a, b, exp;
      int          lat;
      a = $urandom;
      b = $urandom;
      exp = refModel(MULDIV_MULHU, a, b);
      funct3_i = MULDIV_MULHU;
      op_a_i   = a;
      op_b_i   = b;
      start_i  = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat = 1;
      while (done_o !== 1'b1 && lat < TIMEOUT) begin
         if (lat == 5) begin
            start_i  = 1'b1;
            funct3_i = MULDIV_DIV;
            op_a_i   = $urandom;
            op_b_i   = 32'd0;
            #1;
            nCompared++;
            if (busy_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL ignore_busy: got %b expected 1", busy_o); end
         end
         @(posedge clk_i); #1;
         start_i = 1'b0;
         lat++;
      end
      nCompared++;
      if (lat != 33) begin nMismatched++; $display("[TB] FAIL ignore_latency: got %0d expected 33", lat); end
      nCompared++;
      if (result_o !== exp) begin nMismatched++; $display("[TB] FAIL ignore_result: got %h expected %h", result_o, exp); end
      @(posedge clk_i); #1;
   endtask

   task automatic test_flush();
      logic [31:0] prevRes, a, b, res, resAfter, exp;
      int          lat, busyCnt;
      logic        pulseOk;
      // Flush in the middle of CALC
      prevRes  = result_o;
      funct3_i = MULDIV_DIVU;
      op_a_i   = $urandom;
      op_b_i   = $urandom_range(1, 1000);
      start_i  = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      #1;
      nCompared++;
      if (done_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_calc_done: got %b expected 0", done_o); end
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      nCompared++;
      if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_idle_busy: got %b expected 0", busy_o); end
      nCompared++;
      if (done_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_idle_done: got %b expected 0", done_o); end
      nCompared++;
      if (result_o !== prevRes) begin nMismatched++; $display("[TB] FAIL flush_calc_result: got %h expected %h", result_o, prevRes); end
      // A new operation the very next cycle runs to completion
      a = $urandom;
      b = $urandom;
      applyStimulus(MULDIV_MUL, a, b, res, lat, busyCnt, pulseOk, resAfter);
      exp = refModel(MULDIV_MUL, a, b);
      nCompared++;
      if (res !== exp) begin nMismatched++; $display("[TB] FAIL after_flush_result: got %h expected %h", res, exp); end
      nCompared++;
      if (lat != 33) begin nMismatched++; $display("[TB] FAIL after_flush_latency: got %0d expected 33", lat); end
      // Flush landing on the FINISH cycle suppresses completion
      prevRes  = result_o;
      funct3_i = MULDIV_MULHU;
      op_a_i   = $urandom | 32'h80000000;
      op_b_i   = $urandom | 32'h80000000;
      start_i  = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat = 1;
      while (done_o !== 1'b1 && lat < TIMEOUT) begin
         @(posedge clk_i); #1;
         lat++;
      end
      nCompared++;
      if (lat != 33) begin nMismatched++; $display("[TB] FAIL finish_reach_latency: got %0d expected 33", lat); end
      flush_i = 1'b1;
      #1;
      nCompared++;
      if (done_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_finish_done: got %b expected 0", done_o); end
      nCompared++;
      if (result_o !== prevRes) begin nMismatched++; $display("[TB] FAIL flush_finish_result: got %h expected %h", result_o, prevRes); end
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      nCompared++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_finish_after: done %b busy %b expected 0 0", done_o, busy_o); end
      nCompared++;
      if (result_o !== prevRes) begin nMismatched++; $display("[TB] FAIL flush_finish_hold: got %h expected %h", result_o, prevRes); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] res, resAfter;
      int          lat, busyCnt;
      logic        pulseOk;
      funct3_i = MULDIV_MUL;
      op_a_i   = $urandom;
      op_b_i   = $urandom;
      start_i  = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (20) @(posedge clk_i);
      #1;
      nCompared++;
      if (busy_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL midreset_precheck_busy: got %b expected 1", busy_o); end
      rst_i = 1'b0;
      #1;
      nCompared++;
      if (busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy_o); end
      nCompared++;
      if (done_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_done: got %b expected 0", done_o); end
      nCompared++;
      if (result_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL midreset_result: got %h expected 0", result_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      applyStimulus(MULDIV_MULHU, 32'd3, 32'd5, res, lat, busyCnt, pulseOk, resAfter);
      nCompared++;
      if (res !== 32'd0) begin nMismatched++; $display("[TB] FAIL midreset_mulhu_result: got %h expected 0", res); end
      nCompared++;
      if (lat != 33) begin nMismatched++; $display("[TB] FAIL midreset_mulhu_latency: got %0d expected 33", lat); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_flush();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded operands and the decoded funct3 of an M-extension instruction. It computes the result over 32 iterations and presents it alongside the ALU result for the EX/MEM register. While computing, it drives a stall request to the hazard unit so that IF/ID and ID/EX hold their contents.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  ID/EX holds a valid M-extension instruction (opcode 0110011, funct7 0000001).
- flush_i  in  1  kill the in-flight operation (branch/exception flush).
- funct3_i  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  in  32  rs1 value after the forwarding mux.
- op_b_i  in  32  rs2 value after the forwarding mux.
- busy_o  out  1  stall request to the hazard unit (combinational).
- done_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- result_o  out  32  registered result; holds its last value until the next done_o.

## Operation
- FSM states:
  - IDLE: accepts start_i; operands, funct3 and sign flags are latched on that edge.
  - CALC: one shift-add (multiply) or restoring-subtract (divide) step per edge; 5-bit counter from 0 to 31.
  - FINISH: applies the sign fix and result select, asserts done_o, then returns to IDLE.
- Transitions:
  - IDLE→CALC on start_i.
  - CALC→FINISH after the edge that processes count 31.
  - FINISH→IDLE unconditionally.
  - Any state→IDLE on flush_i.
- Signed handling: operands are converted to magnitudes at latch time.
  - MUL: low 32 bits of the product; signedness is irrelevant.
  - MULH: both operands signed. MULHSU: op_a signed, op_b unsigned. MULHU: both unsigned.
  - Multiply: the 64-bit product is negated if the operand signs differ; result is product[63:32], or [31:0] for MUL.
  - DIV/REM: quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Mandatory overrides, applied in FINISH regardless of datapath result:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000; remainder 0.
- start_i while not in IDLE: ignored.
- flush_i has priority over start_i and over FINISH. done_o is not asserted in a flushed cycle, and result_o is unchanged.

## Timing
- Reset values: state IDLE, counter 0, result_o 0, done_o 0, internal accumulators 0. Reset acts immediately and aborts any operation mid-flight.
- busy_o = (state==CALC) | (state==IDLE & start_i & ~flush_i). The pipeline therefore stalls in the same cycle the instruction arrives.
- In FINISH busy_o is 0. ID/EX advances and EX/MEM captures result_o on the edge that ends FINISH.
- Latency: start sampled at edge k → CALC during edges k+1..k+32 → done_o high in the cycle after edge k+32. This gives 33 cycles of busy/stall and 34 cycles in total.
- done_o is high for exactly one cycle per completed operation.
- Back-to-back operations: a new start_i is accepted in the IDLE cycle that follows FINISH.

## Configuration
- Macro: MULDIV_FASTPATH_EN.
- Defined: a divide by zero or signed overflow detected in IDLE goes IDLE→FINISH directly. done_o is then high in the cycle after the start edge, and busy_o is high for 1 cycle.
- Undefined: these cases run the full 32 iterations. FINISH applies the same override values, so results are identical; only latency differs.

## Structure
- Package muldiv_pkg holds:
  - funct3 constants (MULDIV_MUL … MULDIV_REMU);
  - the state enum {IDLE, CALC, FINISH};
  - localparam ITER = 32.
- One natural sub-module, ex_muldiv_sign_fix: combinational negation, result select and divide overrides used in FINISH.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD → result_o 0xFFFFFFEB; done_o is high exactly 33 cycles after the start edge; busy_o is high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0.
  - With MULDIV_FASTPATH_EN: done_o 1 cycle after the start edge.
  - Without it: done_o 33 cycles after the start edge.
- Pulse flush_i at CALC count 10 → IDLE next cycle, no done_o, result_o unchanged. A start_i asserted mid-CALC is ignored. A new start the cycle after the flush completes normally.
- Drive rst_i low at CALC count 20 → outputs 0 immediately. After release, a fresh MULHU 3×5 → result_o 0.
